grid_line_clear_sequencer: RTL and testbench



---
 rtl/grid_line_clear_sequencer.sv | 277 +++++++++++++++++++++++++++
 tb/tb_grid_line_clear_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_line_clear_sequencer.sv
// Line-clear sequencer: scans the playfield bottom-up over grid port A, removes full rows,
// compacts the rest downward and zero-fills the top. Define LINE_CLEAR_SCORE_EN for a score output.
module grid_line_clear_sequencer #(
  parameter int unsigned COLS   = 10,
  parameter int unsigned ROWS   = 20,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [4:0]        lines_cleared,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [19:0]       score
`endif
);

  localparam int unsigned RowW = $clog2(ROWS);
  localparam int unsigned ColW = $clog2(COLS + 1);

  localparam logic [ADDR_W-1:0] ColsA      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] OneA       = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] BottomBase = ADDR_W'((ROWS - 1) * COLS);
  localparam logic [RowW-1:0]   BottomRow  = RowW'(ROWS - 1);
  localparam logic [RowW-1:0]   OneR       = RowW'(1);
  localparam logic [ColW-1:0]   ColsC      = ColW'(COLS);
  localparam logic [ColW-1:0]   LastCol    = ColW'(COLS - 1);
  localparam logic [ColW-1:0]   OneC       = ColW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StCheck,
    StEval,
    StCopyRd,
    StCopyWr,
    StFill,
    StDone
  } state_e;

  state_e            state_q;
  logic [RowW-1:0]   src_row_q, dst_row_q;
  logic [ADDR_W-1:0] src_base_q, dst_base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ColW-1:0]   col_q;  // column of the read being presented (CHECK) or copied (COPY)
  logic [ColW-1:0]   ret_q;  // number of CHECK read words absorbed so far
  logic              rvld_q; // a granted read was performed last cycle; mem_rdata is valid
  logic              full_q;
  logic [4:0]        count_q;
  logic              req_q, busy_q, done_q;
  logic [4:0]        lines_q;

  logic              granted, stall;
  logic [4:0]        count_inc, end_cnt;
  logic [ADDR_W-1:0] end_top;
  logic              end_scan, go_done;

  assign granted = req_q & mem_gnt;
  assign stall   = req_q & ~mem_gnt;

  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_cleared = lines_q;
  assign mem_req       = req_q;
  assign mem_addr      = addr_q;
  assign mem_we        = granted & ((state_q == StCopyWr) | (state_q == StFill));
  assign mem_wdata     = (state_q == StCopyWr) ? mem_rdata : '0;

  assign count_inc = (count_q == 5'd31) ? count_q : count_q + 5'd1;
  assign end_cnt   = ((state_q == StEval) && full_q) ? count_inc : count_q;

  // Top cell of the fill region: last cell of the lowest row that still needs clearing.
  assign end_top = (state_q == StEval) ? dst_base_q + ColsA - OneA : dst_base_q - OneA;

  // The scan ends when the row just retired was row 0 and the FSM would not copy it.
  assign end_scan = granted && (src_row_q == '0) &&
                    (((state_q == StEval) && (full_q || (src_row_q == dst_row_q))) ||
                     ((state_q == StCopyWr) && (col_q == LastCol)));

  assign go_done = (granted && (state_q == StFill) && (addr_q == '0)) ||
                   (end_scan && (end_cnt == 5'd0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      src_row_q  <= '0;
      dst_row_q  <= '0;
      src_base_q <= '0;
      dst_base_q <= '0;
      addr_q     <= '0;
      col_q      <= '0;
      ret_q      <= '0;
      rvld_q     <= 1'b0;
      full_q     <= 1'b0;
      count_q    <= '0;
      req_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      lines_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StReq;
            src_row_q  <= BottomRow;
            dst_row_q  <= BottomRow;
            src_base_q <= BottomBase;
            dst_base_q <= BottomBase;
            count_q    <= '0;
            busy_q     <= 1'b1;
            req_q      <= 1'b1;
          end
        end

        StReq: begin
          if (mem_gnt) begin
            state_q <= StCheck;
            addr_q  <= src_base_q;
            col_q   <= '0;
            ret_q   <= '0;
            rvld_q  <= 1'b0;
            full_q  <= 1'b1;
          end
        end

        StCheck: begin
          if (stall) begin
            rvld_q <= 1'b0;
            if (rvld_q) begin
              // Data due this cycle is dropped; resume issuing from that column.
              col_q  <= ret_q;
              addr_q <= src_base_q + ADDR_W'(ret_q);
            end
          end else begin
            if (rvld_q) begin
              full_q <= full_q & (mem_rdata != '0);
              ret_q  <= ret_q + OneC;
              if (ret_q == LastCol) begin
                state_q <= StEval;
              end
            end
            if (col_q != ColsC) begin
              rvld_q <= 1'b1;
              col_q  <= col_q + OneC;
              addr_q <= addr_q + OneA;
            end else begin
              rvld_q <= 1'b0;
            end
          end
        end

        StEval: begin
          if (!stall) begin
            if (full_q || (src_row_q == dst_row_q)) begin
              src_row_q  <= src_row_q - OneR;
              src_base_q <= src_base_q - ColsA;
              addr_q     <= src_base_q - ColsA;
              if (full_q) begin
                count_q <= count_inc;
              end else begin
                dst_row_q  <= dst_row_q - OneR;
                dst_base_q <= dst_base_q - ColsA;
              end
              state_q <= StCheck;
              col_q   <= '0;
              ret_q   <= '0;
              full_q  <= 1'b1;
            end else begin
              state_q <= StCopyRd;
              col_q   <= '0;
              addr_q  <= src_base_q;
            end
          end
        end

        StCopyRd: begin
          if (stall) begin
            rvld_q <= 1'b0;
          end else begin
            state_q <= StCopyWr;
            addr_q  <= dst_base_q + ADDR_W'(col_q);
            rvld_q  <= 1'b1;
          end
        end

        StCopyWr: begin
          if (stall) begin
            // The word to be written is lost with the grant; read it again.
            rvld_q  <= 1'b0;
            state_q <= StCopyRd;
            addr_q  <= src_base_q + ADDR_W'(col_q);
          end else begin
            rvld_q <= 1'b0;
            if (col_q == LastCol) begin
              src_row_q  <= src_row_q - OneR;
              dst_row_q  <= dst_row_q - OneR;
              src_base_q <= src_base_q - ColsA;
              dst_base_q <= dst_base_q - ColsA;
              addr_q     <= src_base_q - ColsA;
              state_q    <= StCheck;
              col_q      <= '0;
              ret_q      <= '0;
              full_q     <= 1'b1;
            end else begin
              state_q <= StCopyRd;
              col_q   <= col_q + OneC;
              addr_q  <= src_base_q + ADDR_W'(col_q + OneC);
            end
          end
        end

        StFill: begin
          if (!stall) begin
            addr_q <= addr_q - OneA;
          end
        end

        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase

      if (go_done) begin
        state_q <= StDone;
        done_q  <= 1'b1;
        req_q   <= 1'b0;
        lines_q <= end_cnt;
      end else if (end_scan) begin
        state_q <= StFill;
        addr_q  <= end_top;
      end
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [10:0] score_inc;
  logic [20:0] score_sum;
  logic [19:0] score_q;

  always_comb begin
    score_inc = 11'd0;
    case (end_cnt)
      5'd0:    score_inc = 11'd0;
      5'd1:    score_inc = 11'd40;
      5'd2:    score_inc = 11'd100;
      5'd3:    score_inc = 11'd300;
      default: score_inc = 11'd1200;
    endcase
  end

  assign score_sum = {1'b0, score_q} + {10'd0, score_inc};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
    end else if (go_done) begin
      score_q <= score_sum[20] ? 20'hFFFFF : score_sum[19:0];
    end
  end

  assign score = score_q;
`endif

endmodule

// File: tb/tb_grid_line_clear_sequencer.sv
// Bench for grid_line_clear_sequencer: behavioural grid RAM, reference compaction model and a
// scoreboard of expected pass results checked on each done pulse.
`timescale 1ns/1ps
module tb_grid_line_clear_sequencer;

  localparam int COLS      = 10;
  localparam int ROWS      = 20;
  localparam int CELLS     = COLS * ROWS;
  localparam int MaxCycles = 5000;

  typedef struct {
    int lines;
    int score;
  } sb_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [4:0] lines_cleared;
  logic       mem_req;
  logic       mem_gnt;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;
`ifdef LINE_CLEAR_SCORE_EN
  logic [19:0] score;
`endif

  logic [7:0] mem      [256];
  logic [7:0] exp_grid [256];
  logic [7:0] init_mem [256];
  logic [7:0] ref_mem  [256];

  sb_t sb_q[$];
  int  n_checks  = 0;
  int  n_fail    = 0;
  int  done_seen = 0;
  int  we_cnt    = 0;
  int  bad_we    = 0;
  int  exp_score = 0;

  grid_line_clear_sequencer #(
    .COLS  (COLS),
    .ROWS  (ROWS),
    .ADDR_W(8),
    .DATA_W(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .lines_cleared(lines_cleared),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
`ifdef LINE_CLEAR_SCORE_EN
    ,
    .score        (score)
`endif
  );

  always #5 clk = ~clk;

  // Registered single-port RAM, accessed only while the port is granted.
  always @(posedge clk) begin
    if (mem_req && mem_gnt) begin
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] = mem_wdata;
    end
    if (mem_we) we_cnt++;
    if (mem_we && !mem_gnt) bad_we++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : done_mon
    sb_t e;
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        check_eq("done_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check_eq("lines_cleared", 32'(lines_cleared), e.lines);
`ifdef LINE_CLEAR_SCORE_EN
        check_eq("score", 32'(score), e.score);
`endif
      end
      done_seen++;
    end
  end

  function automatic int score_for(input int lines);
    case (lines)
      0:       return 0;
      1:       return 40;
      2:       return 100;
      3:       return 300;
      default: return 1200;
    endcase
  endfunction

  // Reference: keep non-full rows in bottom-up order, stack them from the bottom, zero the rest.
  function automatic int ref_model();
    int  d = ROWS - 1;
    int  lines = 0;
    bit  full;
    for (int i = 0; i < 256; i++) exp_grid[i] = mem[i];
    for (int i = 0; i < CELLS; i++) exp_grid[i] = 8'h00;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (mem[r*COLS+c] == 8'h00) full = 1'b0;
      if (full) begin
        lines++;
      end else begin
        for (int c = 0; c < COLS; c++) exp_grid[d*COLS+c] = mem[r*COLS+c];
        d--;
      end
    end
    return lines;
  endfunction

  function automatic int grid_mismatches();
    int m = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_grid[i]) m++;
    return m;
  endfunction

  function automatic int nz_count(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i < hi; i++) if (mem[i] != 8'h00) n++;
    return n;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic fill_row(input int r, input logic [7:0] v);
    for (int c = 0; c < COLS; c++) mem[r*COLS+c] = v;
  endtask

  task automatic push_expect(input int lines);
    sb_t e;
    exp_score = exp_score + score_for(lines);
    if (exp_score > 20'hFFFFF) exp_score = 20'hFFFFF;
    e.lines = lines;
    e.score = exp_score;
    sb_q.push_back(e);
  endtask

  task automatic run_pass(input string tag, input bit do_stall);
    int seen0;
    int n;
    push_expect(ref_model());
    seen0  = done_seen;
    we_cnt = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check_eq({tag, "_busy"}, 32'(busy), 1);
    if (do_stall) begin
      n = 0;
      while (!mem_we && n < MaxCycles) begin
        @(negedge clk);
        n++;
      end
      check_eq({tag, "_copy_seen"}, 32'(mem_we), 1);
      mem_gnt = 1'b0;
      start   = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (4) @(negedge clk);
      mem_gnt = 1'b1;
    end
    n = 0;
    while (done_seen == seen0 && n < MaxCycles) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_finished"}, done_seen - seen0, 1);
    @(negedge clk);
    check_eq({tag, "_idle"}, 32'(busy), 0);
    check_eq({tag, "_grid"}, grid_mismatches(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset   = 1'b1;
    start   = 1'b0;
    mem_gnt = 1'b1;
    clear_mem();
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_lines", 32'(lines_cleared), 0);
    check_eq("rst_req", 32'(mem_req), 0);
    check_eq("rst_addr", 32'(mem_addr), 0);
    check_eq("rst_wdata", 32'(mem_wdata), 0);
    check_eq("rst_we", 32'(mem_we), 0);
`ifdef LINE_CLEAR_SCORE_EN
    check_eq("rst_score", 32'(score), 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // Empty grid: no writes at all.
    run_pass("empty", 1'b0);
    check_eq("empty_writes", we_cnt, 0);

    // Single full bottom row with one cell above it.
    clear_mem();
    fill_row(19, 8'h03);
    mem[18*COLS+4] = 8'h05;
    run_pass("one_line", 1'b0);
    check_eq("one_line_cell", 32'(mem[19*COLS+4]), 8'h05);
    check_eq("one_line_row19_nz", nz_count(19*COLS, 20*COLS), 1);
    check_eq("one_line_row18_nz", nz_count(18*COLS, 19*COLS), 0);

    // Four full rows.
    clear_mem();
    for (int r = 16; r < 20; r++) fill_row(r, 8'h01);
    mem[15*COLS] = 8'h07;
    run_pass("tetris", 1'b0);
    check_eq("tetris_cell", 32'(mem[19*COLS]), 8'h07);
    check_eq("tetris_upper_nz", nz_count(0, 19*COLS), 0);

    // Two full rows separated by a partial row.
    clear_mem();
    fill_row(19, 8'h0a);
    fill_row(17, 8'hff);
    mem[18*COLS+9] = 8'h02;
    run_pass("gap", 1'b0);
    check_eq("gap_cell", 32'(mem[19*COLS+9]), 8'h02);
    check_eq("gap_upper_nz", nz_count(0, 19*COLS), 0);

    // Random lower half with three full rows; run clean, then again with a grant drop.
    clear_mem();
    for (int r = 8; r < 20; r++)
      for (int c = 0; c < COLS; c++)
        mem[r*COLS+c] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    fill_row(19, 8'h11);
    fill_row(15, 8'h22);
    fill_row(11, 8'h33);
    mem[18*COLS] = 8'h00;
    for (int i = 0; i < 256; i++) init_mem[i] = mem[i];
    run_pass("rand_clean", 1'b0);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int i = 0; i < 256; i++) mem[i] = init_mem[i];
    run_pass("rand_stall", 1'b1);
    n = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
    check_eq("stall_vs_clean", n, 0);
    check_eq("stall_no_we", bad_we, 0);
    repeat (5) @(negedge clk);
    check_eq("busy_start_ignored", 32'(busy), 0);

    // Reset while zero-filling the top rows.
    clear_mem();
    for (int r = 16; r < 20; r++) fill_row(r, 8'h09);
    mem[15*COLS] = 8'h07;
    push_expect(ref_model());
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!(mem_we && mem_addr < 8'(4*COLS)) && n < MaxCycles) begin
      @(negedge clk);
      n++;
    end
    check_eq("fill_reached", 32'(mem_we), 1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 0);
    check_eq("abort_done", 32'(done), 0);
    check_eq("abort_lines", 32'(lines_cleared), 0);
    check_eq("abort_req", 32'(mem_req), 0);
    check_eq("abort_we", 32'(mem_we), 0);
    check_eq("abort_no_done", sb_q.size(), 1);
    sb_q.delete();
    exp_score = 0;
    reset = 1'b0;
    @(negedge clk);
    run_pass("post_reset", 1'b0);

    check_eq("sb_drained", sb_q.size(), 0);
    check_eq("final_no_we_stalled", bad_we, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
